// File: rtl/result_display_driver_if.sv
// Bus between the ALU output mux and the result display driver: capture
// request in, busy status and the multiplexed 7-segment drive out.
interface result_display_driver_if;
    logic       load;
    logic [4:0] result_in;
    logic       signed_mode;
    logic       busy;
    logic [2:0] an;
    logic [6:0] ssd;

    modport master (
        output load, result_in, signed_mode,
        input  busy, an, ssd
    );

    modport slave (
        input  load, result_in, signed_mode,
        output busy, an, ssd
    );
endinterface

// File: rtl/result_display_driver.sv
// Captures a 5-bit ALU result, converts it to sign + two BCD digits with a
// sequential double-dabble, and scans sign/tens/ones over three 7-seg digits.
// Build option: define LEAD_ZERO_BLANK_EN to blank the tens digit when it is zero.
module result_display_driver #(
    parameter int SCAN_DIV = 1024
) (
    input logic                    clk,
    input logic                    reset_n,
    result_display_driver_if.slave bus
);

    localparam int         PW     = $clog2(SCAN_DIV);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_cnt;
    logic [12:0]   r_shift;
    logic          r_neg_c;
    logic          r_busy;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_neg;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [2:0]    r_an;
    logic [6:0]    r_ssd;

    logic          w_neg;
    logic [4:0]    w_mag;
    logic          w_tc;
    logic          w_done;
    logic [PW-1:0] w_presc_nxt;
    logic [1:0]    w_idx_nxt;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    w_ones_nxt;
    logic          w_neg_nxt;
    logic [2:0]    w_an_nxt;
    logic [6:0]    w_ssd_nxt;

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'h3F;
            4'd1:    f_seg7 = 7'h06;
            4'd2:    f_seg7 = 7'h5B;
            4'd3:    f_seg7 = 7'h4F;
            4'd4:    f_seg7 = 7'h66;
            4'd5:    f_seg7 = 7'h6D;
            4'd6:    f_seg7 = 7'h7D;
            4'd7:    f_seg7 = 7'h07;
            4'd8:    f_seg7 = 7'h7F;
            4'd9:    f_seg7 = 7'h6F;
            default: f_seg7 = 7'h00;
        endcase
    endfunction

    // Shift register layout: [12:9] tens, [8:5] ones, [4:0] remaining binary.
    function automatic logic [12:0] f_dabble(input logic [12:0] s);
        logic [3:0] t;
        logic [3:0] o;
        t = (s[12:9] >= 4'd5) ? (s[12:9] + 4'd3) : s[12:9];
        o = (s[8:5]  >= 4'd5) ? (s[8:5]  + 4'd3) : s[8:5];
        f_dabble = {t[2:0], o, s[4:0], 1'b0};
    endfunction

    assign w_neg = bus.signed_mode & bus.result_in[4];
    assign w_mag = w_neg ? (~bus.result_in + 5'd1) : bus.result_in;

    // Next scan position and display contents, decoded ahead so the outputs can be registered.
    always_comb begin
        w_tc = (r_presc == PW'(SCAN_DIV - 1));
        if (w_tc) begin
            w_presc_nxt = {PW{1'b0}};
            w_idx_nxt   = (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
        end else begin
            w_presc_nxt = r_presc + PW'(1);
            w_idx_nxt   = r_idx;
        end
        w_done = (r_state == S_CONV) && (r_cnt == 3'd5);
        if (w_done) begin
            w_tens_nxt = r_shift[12:9];
            w_ones_nxt = r_shift[8:5];
            w_neg_nxt  = r_neg_c;
        end else begin
            w_tens_nxt = r_tens;
            w_ones_nxt = r_ones;
            w_neg_nxt  = r_neg;
        end
        w_an_nxt = 3'b001 << w_idx_nxt;
        case (w_idx_nxt)
            2'd0: w_ssd_nxt = f_seg7(w_ones_nxt);
            2'd1: begin
`ifdef LEAD_ZERO_BLANK_EN
                w_ssd_nxt = (w_tens_nxt == 4'd0) ? 7'h00 : f_seg7(w_tens_nxt);
`else
                w_ssd_nxt = f_seg7(w_tens_nxt);
`endif
            end
            2'd2:    w_ssd_nxt = w_neg_nxt ? 7'h40 : 7'h00;
            default: w_ssd_nxt = 7'h00;
        endcase
    end

    // Capture / convert FSM; one double-dabble iteration per cycle, then hand off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 13'd0;
            r_neg_c <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_state <= S_CONV;
                        r_cnt   <= 3'd0;
                        r_shift <= {8'h00, w_mag};
                        r_neg_c <= w_neg;
                        r_busy  <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (r_cnt == 3'd5) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_shift <= f_dabble(r_shift);
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display digit registers, free-running scan and registered digit drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_neg   <= 1'b0;
            r_presc <= {PW{1'b0}};
            r_idx   <= 2'd0;
            r_an    <= 3'b001;
            r_ssd   <= 7'h3F;
        end else begin
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_neg   <= w_neg_nxt;
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_an    <= w_an_nxt;
            r_ssd   <= w_ssd_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.an   = r_an;
    assign bus.ssd  = r_ssd;

endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver with SCAN_DIV=4: stimulus pushes the
// expected digits, a monitor checks busy length and the scanned digits after each conversion.
module tb_result_display_driver;

    typedef struct {
        logic [6:0] s;
        logic [6:0] t;
        logic [6:0] o;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    bit   mon_en;
    bit   mon_active;
    exp_t sb[$];

    result_display_driver_if bus ();

    result_display_driver #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] tens_code(input logic [6:0] code);
`ifdef LEAD_ZERO_BLANK_EN
        tens_code = (code == 7'h3F) ? 7'h00 : code;
`else
        tens_code = code;
`endif
    endfunction

    function automatic exp_t mk(input logic [6:0] s, input logic [6:0] t, input logic [6:0] o);
        exp_t e;
        e.s = s;
        e.t = tens_code(t);
        e.o = o;
        return e;
    endfunction

    // Drives one load cycle starting at a falling edge; returns at the falling edge after E0.
    task automatic do_load(input logic [4:0] v, input logic m, input exp_t e, input bit push);
        @(negedge clk);
        if (push) sb.push_back(e);
        bus.load        = 1'b1;
        bus.result_in   = v;
        bus.signed_mode = m;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_active) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s timeout: pending=%0d required=0", name, sb.size());
        end
        @(negedge clk);
    endtask

    // Monitor: measures busy length and collects one full scan after busy drops.
    initial begin
        bit         prev;
        int         blen;
        exp_t       e;
        logic [7:0] gs, gt, go;
        prev       = 1'b0;
        blen       = 0;
        mon_active = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                prev       = 1'b0;
                blen       = 0;
                mon_active = 1'b0;
            end else if (bus.busy) begin
                if (!prev) begin
                    mon_active = 1'b1;
                    blen       = 0;
                end
                blen++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_conversion: got=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    chk("busy_len", 8'(blen), 8'd6);
                    gs = 8'hFF;
                    gt = 8'hFF;
                    go = 8'hFF;
                    for (int k = 0; k < 12; k++) begin
                        if (k > 0) begin
                            @(negedge clk);
                            #1;
                        end
                        case (bus.an)
                            3'b001:  go = {1'b0, bus.ssd};
                            3'b010:  gt = {1'b0, bus.ssd};
                            3'b100:  gs = {1'b0, bus.ssd};
                            default: chk("an_onehot", {5'd0, bus.an}, 8'h01);
                        endcase
                    end
                    chk("sign", gs, {1'b0, e.s});
                    chk("tens", gt, {1'b0, e.t});
                    chk("ones", go, {1'b0, e.o});
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_an;
        total           = 0;
        bad             = 0;
        mon_en          = 1'b0;
        reset_n         = 1'b0;
        bus.load        = 1'b0;
        bus.result_in   = 5'd0;
        bus.signed_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_an", {5'd0, bus.an}, 8'h01);
        chk("reset_ssd", {1'b0, bus.ssd}, 8'h3F);
        chk("reset_busy", {7'd0, bus.busy}, 8'h00);

        reset_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            #1;
            exp_an = 3'b001 << ((k / 4) % 3);
            chk("scan_an", {5'd0, bus.an}, {5'd0, exp_an});
            @(negedge clk);
        end
        mon_en = 1'b1;

        do_load(5'b10111, 1'b0, mk(7'h00, 7'h5B, 7'h4F), 1'b1);
        wait_done("u23");
        do_load(5'b11010, 1'b1, mk(7'h40, 7'h3F, 7'h7D), 1'b1);
        wait_done("s_m6");
        do_load(5'b10000, 1'b1, mk(7'h40, 7'h06, 7'h7D), 1'b1);
        wait_done("s_m16");
        do_load(5'b11111, 1'b0, mk(7'h00, 7'h4F, 7'h06), 1'b1);
        wait_done("u31");
        do_load(5'b01111, 1'b1, mk(7'h00, 7'h06, 7'h6D), 1'b1);
        wait_done("s15");
        do_load(5'b11010, 1'b0, mk(7'h00, 7'h5B, 7'h7D), 1'b1);
        wait_done("u26");

        // Second load at E2 must be ignored.
        do_load(5'b10111, 1'b0, mk(7'h00, 7'h5B, 7'h4F), 1'b1);
        @(negedge clk);
        bus.load        = 1'b1;
        bus.result_in   = 5'b00101;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        wait_done("ignore_e2");
        chk("idle_after_e2", {7'd0, bus.busy}, 8'h00);

        // Load held across E6 must also be ignored.
        do_load(5'b10111, 1'b0, mk(7'h00, 7'h5B, 7'h4F), 1'b1);
        repeat (5) @(negedge clk);
        bus.load        = 1'b1;
        bus.result_in   = 5'b00101;
        bus.signed_mode = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        wait_done("ignore_e6");
        chk("idle_after_e6", {7'd0, bus.busy}, 8'h00);

        // Reset pulse at E3 aborts the conversion and clears the display.
        mon_en = 1'b0;
        do_load(5'b10111, 1'b0, mk(7'h00, 7'h00, 7'h00), 1'b0);
        chk("abort_busy_before", {7'd0, bus.busy}, 8'h01);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", {7'd0, bus.busy}, 8'h00);
        chk("abort_an", {5'd0, bus.an}, 8'h01);
        chk("abort_ssd", {1'b0, bus.ssd}, 8'h3F);
        #1 reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_stays_idle", {7'd0, bus.busy}, 8'h00);
        mon_en = 1'b1;
        @(negedge clk);

        do_load(5'b00101, 1'b0, mk(7'h00, 7'h3F, 7'h6D), 1'b1);
        wait_done("u5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
